// File: rtl/ram_stream_reader.sv
// ram_stream_reader: turns a run of sequential 1-cycle-latency RAM reads into a valid/ready stream
module ram_stream_reader #(
  parameter int ITEM_COUNT = 800,
  parameter int DATA_WIDTH = 8,
  localparam int AddressWidth = $clog2(ITEM_COUNT),
  localparam int LengthWidth = $clog2(ITEM_COUNT + 1)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [AddressWidth-1:0] start_address_i,
  input  logic [LengthWidth-1:0]  length_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ram_read_enable_o,
  output logic [AddressWidth-1:0] ram_read_address_o,
  input  logic [DATA_WIDTH-1:0]   ram_read_data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [AddressWidth-1:0] address_q;
  logic [LengthWidth-1:0] length_q, issued_q, sent_q;
  logic in_flight_q, done_q, write_ptr_q, read_ptr_q;
  logic [1:0] count_q, occupancy;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic start_accept, transfer, final_transfer;
  // next state, stream outputs and read-issue credit check
  always_comb begin
    busy_o = state_q == RUN;
    done_o = done_q;
    valid_o = count_q != 2'd0;
    data_o = fifo_q[read_ptr_q];
    last_o = valid_o && sent_q == length_q - 1'b1;
    transfer = valid_o && ready_i;
    final_transfer = transfer && last_o;
    start_accept = !busy_o && start_i;
    occupancy = count_q + {1'b0, in_flight_q};
    ram_read_enable_o = busy_o && issued_q != length_q && (occupancy < 2'd2 || (occupancy == 2'd2 && transfer));
    ram_read_address_o = address_q;
    state_d = start_accept && length_i != '0 ? RUN : final_transfer ? IDLE : state_q;
  end
  // state register
  always_ff @(posedge clock_i) state_q <= reset_i ? IDLE : state_d;
  // address/counters, in-flight tracking and the 2-entry output buffer
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      done_q <= 1'b0;
      in_flight_q <= 1'b0;
      address_q <= '0;
      length_q <= '0;
      issued_q <= '0;
      sent_q <= '0;
      write_ptr_q <= 1'b0;
      read_ptr_q <= 1'b0;
      count_q <= 2'd0;
      fifo_q <= '{default: '0};
    end else begin
      done_q <= (start_accept && length_i == '0) || final_transfer;
      in_flight_q <= ram_read_enable_o;
      address_q <= start_accept ? start_address_i :
                   ram_read_enable_o ? (address_q == AddressWidth'(ITEM_COUNT - 1) ? '0 : address_q + 1'b1) :
                   address_q;
      length_q <= start_accept ? length_i : length_q;
      issued_q <= start_accept ? '0 : issued_q + LengthWidth'(ram_read_enable_o);
      sent_q <= start_accept ? '0 : sent_q + LengthWidth'(transfer);
      if (in_flight_q) fifo_q[write_ptr_q] <= ram_read_data_i;
      write_ptr_q <= write_ptr_q ^ in_flight_q;
      read_ptr_q <= read_ptr_q ^ transfer;
      count_q <= count_q + {1'b0, in_flight_q} - {1'b0, transfer};
    end
  end
endmodule
